// File: rtl/mmio_uart_fifo_mapper_pkg.sv
// Register map constants and STATUS word packing shared by the UART MMIO mapper.
package mmio_uart_fifo_mapper_pkg;

  typedef enum logic [1:0] {
    OFF_TXDATA = 2'd0,
    OFF_RXDATA = 2'd1,
    OFF_STATUS = 2'd2,
    OFF_CTRL   = 2'd3
  } reg_off_e;

  localparam int CH_STRIDE = 4;

  localparam int ST_TX_FULL     = 0;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_RX_NONEMPTY = 2;
  localparam int ST_RX_OVF      = 3;
  localparam int ST_TX_DROP     = 4;
  localparam int ST_TX_CNT_LSB  = 8;
  localparam int ST_RX_CNT_LSB  = 16;

  localparam int CTRL_FLUSH_TX  = 0;
  localparam int CTRL_FLUSH_RX  = 1;
  localparam int CTRL_RX_IRQ_EN = 2;
  localparam int CTRL_CLR_FLAGS = 3;

  typedef struct packed {
    logic       tx_full;
    logic       tx_empty;
    logic       rx_nonempty;
    logic       rx_ovf;
    logic       tx_drop;
    logic [7:0] tx_cnt;
    logic [7:0] rx_cnt;
  } status_t;

  function automatic logic [31:0] pack_status(input status_t s);
    logic [31:0] w;
    w                       = '0;
    w[ST_TX_FULL]           = s.tx_full;
    w[ST_TX_EMPTY]          = s.tx_empty;
    w[ST_RX_NONEMPTY]       = s.rx_nonempty;
    w[ST_RX_OVF]            = s.rx_ovf;
    w[ST_TX_DROP]           = s.tx_drop;
    w[ST_TX_CNT_LSB +: 8]   = s.tx_cnt;
    w[ST_RX_CNT_LSB +: 8]   = s.rx_cnt;
    return w;
  endfunction

endpackage

// File: rtl/mmio_uart_fifo_mapper_sync_fifo.sv
// Single-clock byte FIFO: push/pop/flush, head visible combinationally, 1-cycle push-to-visible.
// Full FIFO still accepts a push when a pop lands in the same cycle; flush overrides both.
module mmio_uart_fifo_mapper_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/mmio_uart_fifo_mapper.sv
// MMIO decoder for NUM_CH UART channels with per-channel TX/RX FIFOs, STATUS/CTRL and level irq.
// Read data registered (1 cycle); TX drains on uart valid&ready; full FIFOs drop and flag.
module mmio_uart_fifo_mapper
  import mmio_uart_fifo_mapper_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 12
) (
  input  logic                  in_clk,
  input  logic                  in_reset_n,
  input  logic [ADDR_W-1:0]     in_address,
  input  logic [31:0]           in_write_data,
  input  logic                  in_write_en,
  input  logic                  in_read_en,
  output logic [31:0]           out_read_data,
  output logic                  out_irq,
  output logic [8*NUM_CH-1:0]   out_uart_tx_data,
  output logic [NUM_CH-1:0]     out_uart_tx_valid,
  input  logic [NUM_CH-1:0]     in_uart_tx_ready,
  input  logic [8*NUM_CH-1:0]   in_uart_rx_data,
  input  logic [NUM_CH-1:0]     in_uart_rx_valid
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  reg_off_e                   off;
  logic                       in_range;
  logic                       rd_only;
  logic [NUM_CH-1:0]          ch_sel;
  logic [NUM_CH-1:0]          rx_nonempty;
  logic [NUM_CH-1:0]          rx_ovf;
  logic [NUM_CH-1:0]          rx_irq_en;
  logic [NUM_CH-1:0][7:0]     rx_head;
  status_t [NUM_CH-1:0]       st;
  logic [31:0]                rd_word;
  logic                       irq_next;
  logic                       unused_wdata;

  assign off          = reg_off_e'(in_address[1:0]);
  assign in_range     = in_address < ADDR_W'(CH_STRIDE * NUM_CH);
  // A read colliding with a write is dropped entirely, including its pop.
  assign rd_only      = in_read_en & ~in_write_en;
  assign unused_wdata = ^in_write_data[31:8];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic          wr_hit;
    logic          rd_hit;
    logic          ctrl_wr;
    logic          tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic          rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic          ovf_set, drop_set, flag_clr;
    logic          ovf_q, drop_q, irq_en_q;

    assign ch_sel[c] = in_range && (in_address[ADDR_W-1:2] == (ADDR_W-2)'(c));
    assign wr_hit    = in_write_en & ch_sel[c];
    assign rd_hit    = rd_only & ch_sel[c];
    assign ctrl_wr   = wr_hit & (off == OFF_CTRL);

    assign tx_push   = wr_hit & (off == OFF_TXDATA);
    assign tx_pop    = ~tx_empty & in_uart_tx_ready[c];
    assign tx_flush  = ctrl_wr & in_write_data[CTRL_FLUSH_TX];
    assign rx_push   = in_uart_rx_valid[c];
    assign rx_pop    = rd_hit & (off == OFF_RXDATA);
    assign rx_flush  = ctrl_wr & in_write_data[CTRL_FLUSH_RX];

    mmio_uart_fifo_mapper_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk      (in_clk),
      .rst_n    (in_reset_n),
      .push     (tx_push),
      .push_dat (in_write_data[7:0]),
      .pop      (tx_pop),
      .flush    (tx_flush),
      .full     (tx_full),
      .empty    (tx_empty),
      .count    (tx_cnt),
      .head     (out_uart_tx_data[8*c +: 8])
    );

    mmio_uart_fifo_mapper_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk      (in_clk),
      .rst_n    (in_reset_n),
      .push     (rx_push),
      .push_dat (in_uart_rx_data[8*c +: 8]),
      .pop      (rx_pop),
      .flush    (rx_flush),
      .full     (rx_full),
      .empty    (rx_empty),
      .count    (rx_cnt),
      .head     (rx_head[c])
    );

    // A byte is only lost when the FIFO stays full; a concurrent flush discards it silently.
    assign drop_set = tx_push & tx_full & ~tx_pop & ~tx_flush;
    assign ovf_set  = rx_push & rx_full & ~(rx_pop & ~rx_empty) & ~rx_flush;
    assign flag_clr = ctrl_wr & in_write_data[CTRL_CLR_FLAGS];

    always_ff @(posedge in_clk) begin
      if (!in_reset_n) begin
        ovf_q    <= 1'b0;
        drop_q   <= 1'b0;
        irq_en_q <= 1'b0;
      end else begin
        ovf_q  <= ovf_set  | (ovf_q  & ~flag_clr);
        drop_q <= drop_set | (drop_q & ~flag_clr);
        if (ctrl_wr) irq_en_q <= in_write_data[CTRL_RX_IRQ_EN];
      end
    end

    assign out_uart_tx_valid[c] = ~tx_empty;
    assign rx_nonempty[c]       = ~rx_empty;
    assign rx_ovf[c]            = ovf_q;
    assign rx_irq_en[c]         = irq_en_q;
    assign st[c] = '{tx_full:     tx_full,
                     tx_empty:    tx_empty,
                     rx_nonempty: ~rx_empty,
                     rx_ovf:      ovf_q,
                     tx_drop:     drop_q,
                     tx_cnt:      8'(tx_cnt),
                     rx_cnt:      8'(rx_cnt)};
  end

  always_comb begin
    rd_word = '0;
    if (rd_only) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_sel[c]) begin
          case (off)
            OFF_RXDATA: rd_word = {24'b0, rx_nonempty[c] ? rx_head[c] : 8'h00};
            OFF_STATUS: rd_word = pack_status(st[c]);
            OFF_CTRL:   rd_word = {29'b0, rx_irq_en[c], 2'b0};
            default:    rd_word = '0;
          endcase
        end
      end
    end
  end

  assign irq_next = (|(rx_irq_en & rx_nonempty)) | (|rx_ovf);

  always_ff @(posedge in_clk) begin
    if (!in_reset_n) begin
      out_read_data <= '0;
      out_irq       <= 1'b0;
    end else begin
      if (in_read_en) out_read_data <= rd_word;
      out_irq <= irq_next;
    end
  end

endmodule

// File: tb/tb_mmio_uart_fifo_mapper.sv
// Directed bench for mmio_uart_fifo_mapper (NUM_CH=2, FIFO_DEPTH=8) with hand-computed expectations.
module tb_mmio_uart_fifo_mapper;

  logic        in_clk = 1'b0;
  logic        in_reset_n;
  logic [11:0] in_address;
  logic [31:0] in_write_data;
  logic        in_write_en;
  logic        in_read_en;
  logic [31:0] out_read_data;
  logic        out_irq;
  logic [15:0] out_uart_tx_data;
  logic [1:0]  out_uart_tx_valid;
  logic [1:0]  in_uart_tx_ready;
  logic [15:0] in_uart_rx_data;
  logic [1:0]  in_uart_rx_valid;

  int n_checks = 0;
  int n_errors = 0;

  mmio_uart_fifo_mapper #(.NUM_CH(2), .FIFO_DEPTH(8), .ADDR_W(12)) dut (
    .in_clk            (in_clk),
    .in_reset_n        (in_reset_n),
    .in_address        (in_address),
    .in_write_data     (in_write_data),
    .in_write_en       (in_write_en),
    .in_read_en        (in_read_en),
    .out_read_data     (out_read_data),
    .out_irq           (out_irq),
    .out_uart_tx_data  (out_uart_tx_data),
    .out_uart_tx_valid (out_uart_tx_valid),
    .in_uart_tx_ready  (in_uart_tx_ready),
    .in_uart_rx_data   (in_uart_rx_data),
    .in_uart_rx_valid  (in_uart_rx_valid)
  );

  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic do_reset();
    in_reset_n = 1'b0;
    repeat (2) tick();
    in_reset_n = 1'b1;
  endtask

  task automatic mmio_wr(input logic [11:0] addr, input logic [31:0] data);
    in_address    = addr;
    in_write_data = data;
    in_write_en   = 1'b1;
    tick();
    in_write_en   = 1'b0;
  endtask

  task automatic mmio_rd(input logic [11:0] addr, output logic [31:0] data);
    in_address = addr;
    in_read_en = 1'b1;
    tick();
    in_read_en = 1'b0;
    data       = out_read_data;
  endtask

  task automatic rx_byte(input int ch, input logic [7:0] b);
    in_uart_rx_data[8*ch +: 8] = b;
    in_uart_rx_valid[ch]       = 1'b1;
    tick();
    in_uart_rx_valid[ch]       = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    in_reset_n       = 1'b0;
    in_address       = '0;
    in_write_data    = '0;
    in_write_en      = 1'b0;
    in_read_en       = 1'b0;
    in_uart_tx_ready = '0;
    in_uart_rx_data  = '0;
    in_uart_rx_valid = '0;

    // 1. reset state
    do_reset();
    check("rst_irq", 32'(out_irq), 32'd0);
    check("rst_txv", 32'(out_uart_tx_valid), 32'd0);
    check("rst_rdata", out_read_data, 32'd0);
    mmio_rd(12'd2, rd);
    check("rst_status0", rd, 32'h0000_0002);

    // 2. buffered TX on ch1, then drain on consecutive cycles
    mmio_wr(12'd4, 32'h41);
    mmio_wr(12'd4, 32'h42);
    mmio_wr(12'd4, 32'h43);
    check("tx1_valid", 32'(out_uart_tx_valid[1]), 32'd1);
    mmio_rd(12'd6, rd);
    check("tx1_status", rd, 32'h0000_0300);
    in_uart_tx_ready[1] = 1'b1;
    check("tx1_b0", 32'(out_uart_tx_data[15:8]), 32'h41);
    tick();
    check("tx1_b1", 32'(out_uart_tx_data[15:8]), 32'h42);
    tick();
    check("tx1_b2", 32'(out_uart_tx_data[15:8]), 32'h43);
    tick();
    check("tx1_drained", 32'(out_uart_tx_valid[1]), 32'd0);
    in_uart_tx_ready[1] = 1'b0;

    // 3. RX overflow on ch0, read-out order, empty read, flag clear
    for (int i = 1; i <= 9; i++) rx_byte(0, 8'(i));
    mmio_rd(12'd2, rd);
    check("ovf_status", rd, 32'h0008_000E);
    check("ovf_irq", 32'(out_irq), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      mmio_rd(12'd1, rd);
      check($sformatf("rx_pop%0d", i), rd, 32'(i));
    end
    mmio_rd(12'd1, rd);
    check("rx_empty_rd", rd, 32'd0);
    mmio_wr(12'd3, 32'h8);
    mmio_rd(12'd2, rd);
    check("ovf_cleared", rd, 32'h0000_0002);
    check("ovf_irq_low", 32'(out_irq), 32'd0);

    // 4. rx irq enable: rise one cycle after byte lands, fall one cycle after pop
    mmio_wr(12'd3, 32'h4);
    rx_byte(0, 8'h55);
    check("irq_not_yet", 32'(out_irq), 32'd0);
    tick();
    check("irq_rise", 32'(out_irq), 32'd1);
    mmio_rd(12'd1, rd);
    check("irq_rx_byte", rd, 32'h55);
    check("irq_still", 32'(out_irq), 32'd1);
    tick();
    check("irq_fall", 32'(out_irq), 32'd0);
    check("rdata_hold", out_read_data, 32'h55);

    // 5. full-FIFO simultaneous push/pop, then flush + push
    for (int i = 0; i < 8; i++) rx_byte(0, 8'h10 + 8'(i));
    in_address              = 12'd1;
    in_read_en              = 1'b1;
    in_uart_rx_data[7:0]    = 8'h18;
    in_uart_rx_valid[0]     = 1'b1;
    tick();
    in_read_en              = 1'b0;
    in_uart_rx_valid[0]     = 1'b0;
    check("rx_popush_data", out_read_data, 32'h10);
    mmio_rd(12'd2, rd);
    check("rx_popush_status", rd, 32'h0008_0006);
    for (int i = 0; i < 8; i++) mmio_wr(12'd0, 32'h20 + 32'(i));
    in_uart_tx_ready[0] = 1'b1;
    mmio_wr(12'd0, 32'h28);
    in_uart_tx_ready[0] = 1'b0;
    check("tx_popush_head", 32'(out_uart_tx_data[7:0]), 32'h21);
    mmio_rd(12'd2, rd);
    check("tx_popush_status", rd, 32'h0008_0805);
    in_uart_rx_data[7:0] = 8'h99;
    in_uart_rx_valid[0]  = 1'b1;
    mmio_wr(12'd3, 32'h7);
    in_uart_rx_valid[0]  = 1'b0;
    mmio_rd(12'd2, rd);
    check("flush_status", rd, 32'h0000_0002);
    check("flush_txv", 32'(out_uart_tx_valid[0]), 32'd0);
    mmio_rd(12'd3, rd);
    check("ctrl_rb", rd, 32'h0000_0004);
    mmio_wr(12'd3, 32'h0);

    // 6. out-of-range accesses, read/write collision, mid-transfer reset
    mmio_rd(12'd2, rd);
    mmio_rd(12'd8, rd);
    check("oor_rd8", rd, 32'd0);
    mmio_rd(12'd6, rd);
    mmio_rd(12'hFFF, rd);
    check("oor_rdfff", rd, 32'd0);
    mmio_wr(12'd8, 32'hFFFF_FFFF);
    mmio_wr(12'hFFF, 32'h0000_00FF);
    mmio_rd(12'd2, rd);
    check("oor_status0", rd, 32'h0000_0002);
    mmio_rd(12'd6, rd);
    check("oor_status1", rd, 32'h0000_0002);
    check("oor_txv", 32'(out_uart_tx_valid), 32'd0);
    in_address    = 12'd4;
    in_write_data = 32'h99;
    in_write_en   = 1'b1;
    in_read_en    = 1'b1;
    tick();
    in_write_en   = 1'b0;
    in_read_en    = 1'b0;
    check("rdwr_rdata", out_read_data, 32'd0);
    check("rdwr_txv1", 32'(out_uart_tx_valid[1]), 32'd1);
    mmio_wr(12'd4, 32'h62);
    rx_byte(0, 8'h77);
    mmio_wr(12'd3, 32'h4);
    mmio_rd(12'd2, rd);
    check("pre_rst_status", rd, 32'h0001_0006);
    in_uart_tx_ready[1] = 1'b1;
    do_reset();
    in_uart_tx_ready[1] = 1'b0;
    check("mid_rst_txv", 32'(out_uart_tx_valid), 32'd0);
    check("mid_rst_irq", 32'(out_irq), 32'd0);
    check("mid_rst_rdata", out_read_data, 32'd0);
    mmio_rd(12'd2, rd);
    check("mid_rst_status0", rd, 32'h0000_0002);
    mmio_rd(12'd6, rd);
    check("mid_rst_status1", rd, 32'h0000_0002);
    mmio_rd(12'd3, rd);
    check("mid_rst_ctrl0", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
